// File: rtl/bcm_baseline_subtract.sv
// Per-channel DC baseline removal for the bunch current monitor ADC stream.
// The baseline is learned during beam-free gates (block average, then EMA).
module bcm_baseline_subtract #(
  parameter int CHANNEL_COUNT         = 4,
  parameter int AXI_SAMPLES_PER_CLOCK = 2,
  parameter int AXI_SAMPLE_WIDTH      = 16,
  parameter int ADC_WIDTH             = 14,
  parameter int INIT_LOG2             = 8,
  parameter int ALPHA_SHIFT           = 6
) (
  input  logic                                                          adcClk,
  input  logic                                                          adcResetN,
  input  logic                                                          inValid,
  input  logic [CHANNEL_COUNT*AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] inData,
  input  logic                                                          baselineGate,
  input  logic                                                          reinit,
  output logic                                                          outValid,
  output logic [CHANNEL_COUNT*AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] outData,
  output logic                                                          baselineReady,
  input  logic [((CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1)-1:0]  baselineSel,
  output logic [31:0]                                                   baselineValue
);

  localparam int LANES     = CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK;
  localparam int DATA_W    = LANES * AXI_SAMPLE_WIDTH;
  localparam int ADC_SHIFT = AXI_SAMPLE_WIDTH - ADC_WIDTH;
  localparam int SPC_LOG2  = $clog2(AXI_SAMPLES_PER_CLOCK);
  localparam int SUM_W     = ADC_WIDTH + SPC_LOG2;
  localparam int BASE_W    = ADC_WIDTH + ALPHA_SHIFT + 1;
  localparam int INT_W     = BASE_W - ALPHA_SHIFT;
  localparam int ACC_W     = ADC_WIDTH + INIT_LOG2 + 1;
  localparam int CNT_W     = INIT_LOG2 + 1;
  localparam int DIFF_W    = ADC_WIDTH + 2;

  localparam logic [CNT_W-1:0]         LAST_INIT_BEAT = CNT_W'((2 ** INIT_LOG2) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_MAX        = DIFF_W'((2 ** (ADC_WIDTH - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_MIN        = DIFF_W'(-(2 ** (ADC_WIDTH - 1)));

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Clip a corrected sample to the ADC range and left-adjust it in its field.
  function automatic logic [AXI_SAMPLE_WIDTH-1:0] sat_pack(input logic signed [DIFF_W-1:0] diff);
    logic signed [ADC_WIDTH-1:0] clip;
    if (diff > SAT_MAX) begin
      clip = SAT_MAX[ADC_WIDTH-1:0];
    end else if (diff < SAT_MIN) begin
      clip = SAT_MIN[ADC_WIDTH-1:0];
    end else begin
      clip = diff[ADC_WIDTH-1:0];
    end
    return AXI_SAMPLE_WIDTH'(clip) << ADC_SHIFT;
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ready_q, ready_d;
  logic signed [ACC_W-1:0]   acc_q  [CHANNEL_COUNT];
  logic signed [ACC_W-1:0]   acc_d  [CHANNEL_COUNT];
  logic signed [BASE_W-1:0]  base_q [CHANNEL_COUNT];
  logic signed [BASE_W-1:0]  base_d [CHANNEL_COUNT];

  logic signed [ADC_WIDTH-1:0] adc_s      [LANES];
  logic signed [ADC_WIDTH-1:0] mean_s     [CHANNEL_COUNT];
  logic signed [INT_W-1:0]     int_base_s [CHANNEL_COUNT];
  logic                        gated_s;

  logic                      s1_valid_q, s1_valid_d;
  logic signed [DIFF_W-1:0]  diff_q [LANES];
  logic signed [DIFF_W-1:0]  diff_d [LANES];
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [31:0]               base_val_q, base_val_d;

  // The low pad bits of each field carry no ADC information.
  logic unused_s;
  assign unused_s = ^inData;

  assign gated_s = inValid && baselineGate;

  // Sample extraction, per-channel beat mean and the integer baseline in use.
  always_comb begin
    logic signed [SUM_W-1:0] sum_v;
    sum_v = '0;
    for (int l = 0; l < LANES; l++) begin
      adc_s[l] = inData[l*AXI_SAMPLE_WIDTH + ADC_SHIFT +: ADC_WIDTH];
    end
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      sum_v = '0;
      for (int k = 0; k < AXI_SAMPLES_PER_CLOCK; k++) begin
        sum_v = sum_v + SUM_W'(adc_s[c*AXI_SAMPLES_PER_CLOCK + k]);
      end
      mean_s[c]     = ADC_WIDTH'(sum_v >>> SPC_LOG2);
      int_base_s[c] = (state_q == ST_TRACK) ? INT_W'(base_q[c] >>> ALPHA_SHIFT) : '0;
    end
  end

  // Baseline learning state machine: block average in INIT, EMA in TRACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    acc_d   = acc_q;
    base_d  = base_q;
    if (reinit) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      ready_d = 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        acc_d[c]  = '0;
        base_d[c] = '0;
      end
    end else begin
      case (state_q)
        ST_INIT: begin
          if (gated_s) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
              acc_d[c] = acc_q[c] + ACC_W'(mean_s[c]);
            end
            if (cnt_q == LAST_INIT_BEAT) begin
              for (int c = 0; c < CHANNEL_COUNT; c++) begin
                base_d[c] = BASE_W'(acc_d[c] >>> INIT_LOG2) <<< ALPHA_SHIFT;
                acc_d[c]  = '0;
              end
              cnt_d   = '0;
              ready_d = 1'b1;
              state_d = ST_TRACK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_TRACK: begin
          if (gated_s) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
              base_d[c] = base_q[c] + BASE_W'(mean_s[c]) - (base_q[c] >>> ALPHA_SHIFT);
            end
          end else begin
            base_d = base_q;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // Learning state registers.
  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        acc_q[c]  <= '0;
        base_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
    end
  end

  // Two-stage correction pipe: subtract, then saturate and repack.
  always_comb begin
    s1_valid_d  = inValid;
    out_valid_d = s1_valid_q;
    diff_d      = diff_q;
    out_data_d  = out_data_q;
    if (inValid) begin
      for (int l = 0; l < LANES; l++) begin
        diff_d[l] = DIFF_W'(adc_s[l]) - DIFF_W'(int_base_s[l / AXI_SAMPLES_PER_CLOCK]);
      end
    end else begin
      diff_d = diff_q;
    end
    if (s1_valid_q) begin
      for (int l = 0; l < LANES; l++) begin
        out_data_d[l*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH] = sat_pack(diff_q[l]);
      end
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        diff_q[l] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      diff_q      <= diff_d;
    end
  end

  // Baseline readback mux; unselectable channels read as zero.
  always_comb begin
    if (32'(baselineSel) < CHANNEL_COUNT) begin
      base_val_d = 32'(base_q[baselineSel]);
    end else begin
      base_val_d = '0;
    end
  end

  // Readback register.
  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      base_val_q <= '0;
    end else begin
      base_val_q <= base_val_d;
    end
  end

  assign outValid      = out_valid_q;
  assign outData       = out_data_q;
  assign baselineReady = ready_q;
  assign baselineValue = base_val_q;

endmodule

// File: tb/tb_bcm_baseline_subtract.sv
// Scoreboard bench for bcm_baseline_subtract: directed beats push expected
// output words; a monitor pops and compares them as outValid appears.
`timescale 1ns/1ps
module tb_bcm_baseline_subtract;

  localparam int CH    = 4;
  localparam int SPC   = 2;
  localparam int SW    = 16;
  localparam int LANES = CH * SPC;
  localparam int DW    = LANES * SW;

  logic          adcClk       = 1'b0;
  logic          adcResetN    = 1'b0;
  logic          inValid      = 1'b0;
  logic [DW-1:0] inData       = '0;
  logic          baselineGate = 1'b0;
  logic          reinit       = 1'b0;
  logic [1:0]    baselineSel  = 2'd0;
  logic          outValid;
  logic [DW-1:0] outData;
  logic          baselineReady;
  logic [31:0]   baselineValue;

  bcm_baseline_subtract #(
    .CHANNEL_COUNT(CH), .AXI_SAMPLES_PER_CLOCK(SPC), .AXI_SAMPLE_WIDTH(SW),
    .ADC_WIDTH(14), .INIT_LOG2(8), .ALPHA_SHIFT(6)
  ) dut (
    .adcClk(adcClk), .adcResetN(adcResetN), .inValid(inValid), .inData(inData),
    .baselineGate(baselineGate), .reinit(reinit), .outValid(outValid),
    .outData(outData), .baselineReady(baselineReady), .baselineSel(baselineSel),
    .baselineValue(baselineValue)
  );

  always #5 adcClk = ~adcClk;

  int cyc = 0;
  always @(posedge adcClk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (%h) expected %0d (%h) (t=%0t)",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [SW-1:0] f);
    return {LANES{f}};
  endfunction

  // Drive one beat at a falling edge; valid beats queue their expected output.
  task automatic beat(input logic v, input logic g, input logic r,
                      input logic [DW-1:0] d, input logic [DW-1:0] e);
    exp_t x;
    inValid      = v;
    baselineGate = g;
    reinit       = r;
    inData       = d;
    if (v) begin
      x.data = e;
      x.due  = cyc + 2;
      sb_q.push_back(x);
    end
    @(negedge adcClk);
    inValid      = 1'b0;
    baselineGate = 1'b0;
    reinit       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge adcClk);
  endtask

  // Monitor: compare every output beat against the scoreboard, check hold otherwise.
  initial begin
    exp_t          x;
    logic [DW-1:0] last_out;
    last_out = '0;
    forever begin
      @(negedge adcClk);
      if (!adcResetN) begin
        last_out = '0;
      end else if (outValid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h with nothing expected", outData);
        end else begin
          x = sb_q.pop_front();
          check("out_data", outData, x.data);
          check32("out_latency", cyc, x.due);
        end
        last_out = outData;
      end else begin
        check("out_hold", outData, last_out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expected beats pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int            bm;
    logic [DW-1:0] mixed;
    mixed = {16'h0004, 16'h0000, 16'hFE6C, 16'hFE70, 16'h0190, 16'h0190, 16'h0198, 16'h018C};

    // Reset state
    repeat (3) @(negedge adcClk);
    check32("rst_out_valid", 32'(outValid), 32'd0);
    check("rst_out_data", outData, '0);
    check32("rst_ready", 32'(baselineReady), 32'd0);
    check32("rst_base_val", baselineValue, 32'd0);
    adcResetN = 1'b1;
    idle(1);

    // Learn a constant 100 baseline; INIT passes raw samples through
    for (int i = 0; i < 256; i++) begin
      beat(1'b1, 1'b1, 1'b0, rep(16'h0190), rep(16'h0190));
      if (i >= 254) check32("ready_rise", 32'(baselineReady), (i == 255) ? 32'd1 : 32'd0);
    end
    idle(1);
    check32("base_100", baselineValue, 32'd6400);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 1'b0, rep(16'h0190), rep(16'h0000));
    idle(1);
    check32("base_track_steady", baselineValue, 32'd6400);

    // Ungated correction and saturation, with a bubble between beats
    beat(1'b1, 1'b0, 1'b0, rep(16'h1130), rep(16'h0FA0));
    idle(1);
    beat(1'b1, 1'b0, 1'b0, {{4{16'h7FFC}}, {4{16'h8000}}}, {{4{16'h7E6C}}, {4{16'h8000}}});
    idle(3);
    check32("base_ungated_hold", baselineValue, 32'd6400);

    // reinit alone, partial learn, then reinit together with a gated beat
    beat(1'b0, 1'b0, 1'b1, '0, '0);
    check32("ready_fall", 32'(baselineReady), 32'd0);
    for (int i = 0; i < 100; i++) beat(1'b1, 1'b1, 1'b0, rep(16'h1F40), rep(16'h1F40));
    beat(1'b1, 1'b1, 1'b1, rep(16'h1F40), rep(16'h1F40));
    check32("ready_after_reinit", 32'(baselineReady), 32'd0);
    for (int i = 0; i < 256; i++) begin
      beat(1'b1, 1'b1, 1'b0, mixed, mixed);
      if (i >= 254) check32("relearn_ready", 32'(baselineReady), (i == 255) ? 32'd1 : 32'd0);
    end
    baselineSel = 2'd0; idle(1); check32("relearn_ch0", baselineValue, 32'd6400);
    baselineSel = 2'd1; idle(1); check32("relearn_ch1", baselineValue, 32'd6400);
    baselineSel = 2'd2; idle(1); check32("relearn_ch2", baselineValue, -32'sd6464);
    baselineSel = 2'd3; idle(1); check32("relearn_ch3", baselineValue, 32'd0);
    baselineSel = 2'd0;
    beat(1'b1, 1'b0, 1'b0, '0,
         {16'h0000, 16'h0000, 16'h0194, 16'h0194, 16'hFE70, 16'hFE70, 16'hFE70, 16'hFE70});
    idle(2);

    // EMA from B=0 with m=64: B <= B + 64 - (B >>> 6)
    beat(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 256; i++) beat(1'b1, 1'b1, 1'b0, '0, '0);
    idle(1);
    check32("base_zero", baselineValue, 32'd0);
    bm = 0;
    for (int j = 0; j < 64; j++) begin
      beat(1'b1, 1'b1, 1'b0, rep(16'h0100), rep(SW'((64 - (bm >>> 6)) * 4)));
      bm = bm + 64 - (bm >>> 6);
      idle(1);
      check32("ema_step", baselineValue, 32'(bm));
    end

    // Asynchronous reset in the middle of a valid stream
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, rep(16'h0190), rep(SW'((100 - (bm >>> 6)) * 4)));
    inValid = 1'b1;
    inData  = rep(16'h0190);
    #2;
    adcResetN = 1'b0;
    #1;
    check32("async_out_valid", 32'(outValid), 32'd0);
    check("async_out_data", outData, '0);
    check32("async_ready", 32'(baselineReady), 32'd0);
    sb_q.delete();
    idle(2);
    inValid = 1'b0;
    adcResetN = 1'b1;
    idle(1);
    check32("post_rst_ready", 32'(baselineReady), 32'd0);
    check32("post_rst_base", baselineValue, 32'd0);
    beat(1'b1, 1'b0, 1'b0, rep(16'h0190), rep(16'h0190));

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) idle(1);
    check32("sb_drain", 32'(sb_q.size()), 32'd0);
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
